ysyx_24080014_ifu_axi_rd: RTL and testbench
===========================================

Name: ysyx_24080014_ifu_axi_rd

Overview:
- AXI4-Lite read initiator for instruction fetch, sitting between the IFU PC logic and the instruction SRAM responder.
- Accepts one fetch request at a time from the PC stage, runs the AR/R handshakes, and captures the returned word and response.
- Presents the instruction to decode with valid/ready backpressure.
- Supports pipeline flush, a misaligned-address check, and a per-fetch latency counter for performance statistics.

Parameters:
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction/RDATA width.
- LAT_W, 16, width of the latency counter; saturating.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- req_valid  in  1  PC stage has a fetch address
- req_ready  out  1  block accepts the request this cycle
- req_addr  in  ADDR_W  fetch PC
- flush  in  1  discard in-flight or held fetch
- ARVALID  out  1  read address valid
- ARREADY  in  1  responder accepted address
- ARADDR  out  ADDR_W  read address
- RVALID  in  1  read data valid
- RREADY  out  1  initiator accepts data
- RDATA  in  DATA_W  read data
- RRESP  in  2  read response (00 OKAY)
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst_data  out  DATA_W  fetched word
- inst_addr  out  ADDR_W  PC of the fetched word
- inst_err  out  2  00 ok, 01 bus error (RRESP!=00), 10 misaligned
- last_lat  out  LAT_W  latency of the last completed fetch

Behaviour:
- Reset (ARESETn low, async): state IDLE; ARVALID=0, ARADDR=0, RREADY=0, inst_valid=0, inst_data=0, inst_addr=0, inst_err=0, last_lat=0, discard flag=0. req_ready is 0 while ARESETn is low and 1 in the first cycle after release.
- States: IDLE, AR, R, HOLD.
- req_ready = !flush && (IDLE || (HOLD && inst_ready)). A request is accepted on req_valid && req_ready.
- Accept, aligned (req_addr[1:0]==0): latch the address into ARADDR and inst_addr, go to AR. ARVALID rises the next cycle. Latency counter loads 1.
- Accept, misaligned: no bus transaction. Go to HOLD with inst_err=10 and inst_data=0.
- AR state:
  - ARVALID=1 and RREADY=1.
  - ARADDR is held stable until ARVALID&&ARREADY.
  - ARVALID is never dropped before the handshake, flush included.
- AR handshake:
  - Without RVALID: go to R.
  - With RVALID in the same cycle (combinational responder): capture RDATA/RRESP and complete directly, as for R below.
- R state:
  - ARVALID=0, RREADY=1.
  - On RVALID: capture inst_data=RDATA; inst_err=01 if RRESP!=00, else 00.
  - Then go to HOLD, or to IDLE if the discard flag is set.
- Latency counter:
  - Increments once per cycle in AR/R until the R handshake.
  - last_lat = cycles from the first ARVALID-high cycle to the R-handshake cycle, inclusive.
  - last_lat is loaded at R handshake only when the fetch is not discarded.
  - Saturates at all-ones.
- HOLD state:
  - inst_valid=1.
  - inst_data, inst_addr and inst_err are stable while inst_ready=0.
  - On inst_ready: go to IDLE, or accept a new request the same cycle if req_valid (back-to-back), going to AR/HOLD as above.
- Flush by state:
  - IDLE: no effect; request blocked that cycle.
  - AR or R: set the discard flag. The transaction completes on the bus (RREADY stays 1), the beat is dropped, the state returns to IDLE and the flag clears. inst_valid never asserts for it.
  - HOLD: inst_valid drops the next cycle and the state goes to IDLE. Flush wins over inst_ready.
  - Flush in the same cycle as the R handshake discards that beat.
- Only one transaction outstanding; no new AR is issued until the prior R handshake completes.
- Reset mid-transaction returns immediately to the reset values; the responder is reset by the same ARESETn.

Test Plan:
- Reset: hold ARESETn low 3 cycles with req_valid=1 -> ARVALID=0, inst_valid=0, req_ready=0. After release req_ready=1 and the first AR is issued the next cycle.
- Slow responder: req_addr=0x80000000; ARREADY one cycle after ARVALID; RVALID two cycles later with RDATA=0x00000413, RRESP=00 -> inst_valid=1, inst_data=0x00000413, inst_addr=0x80000000, inst_err=00, last_lat=4.
- Combinational responder: ARREADY and RVALID high in the first ARVALID cycle with RDATA=0x00100093 -> inst_valid asserts the next cycle, last_lat=1, and ARVALID is high for exactly 1 cycle.
- Backpressure and back-to-back:
  - inst_ready=0 for 5 cycles -> inst_data stable and no ARVALID.
  - inst_ready=1 with req_valid=1 and req_addr=0x80000004 -> ARVALID the next cycle with ARADDR=0x80000004.
- Flush in R: assert flush for 1 cycle while waiting for RVALID -> the RVALID beat is accepted, inst_valid stays 0 and the block returns to IDLE. The next fetch of 0x80000008 returns correct data and last_lat.
- Errors:
  - req_addr=0x80000002 -> no ARVALID; inst_err=10.
  - Fetch with RRESP=10 -> inst_err=01 and inst_data=RDATA.

Source files
------------

// File: rtl/ysyx_24080014_ifu_axi_rd.sv
// ysyx_24080014_ifu_axi_rd -- AXI4-Lite read initiator for instruction fetch (rev 1.0)
// One fetch in flight; flushed fetches still complete on the bus but never reach decode.
`timescale 1ns/1ps
`default_nettype none

module ysyx_24080014_ifu_axi_rd #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT_W  = 16
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic [ADDR_W-1:0] ARADDR,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [1:0]        inst_err,
    output logic [LAT_W-1:0]  last_lat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [1:0]       ERR_OK    = 2'b00;
    localparam logic [1:0]       ERR_BUS   = 2'b01;
    localparam logic [1:0]       ERR_ALIGN = 2'b10;
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_MAX   = {LAT_W{1'b1}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
    logic [DATA_W-1:0]   inst_data_q, inst_data_d;
    logic [1:0]          inst_err_q, inst_err_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [LAT_W-1:0]    last_lat_q, last_lat_d;
    logic                discard_q, discard_d;

    logic                accept;
    logic                misaligned;
    logic                ar_hs;
    logic                r_hs;
    logic                drop;
    logic [LAT_W-1:0]    lat_inc;

    // Gating on ARESETn keeps req_ready low for the whole reset window.
    assign req_ready  = ARESETn && !flush &&
                        ((state_q == S_IDLE) || ((state_q == S_HOLD) && inst_ready));
    assign accept     = req_valid && req_ready;
    assign misaligned = |req_addr[1:0];

    assign ar_hs   = (state_q == S_AR) && ARREADY;
    // The R beat is only meaningful once the address has been (or is being) accepted.
    assign r_hs    = RVALID && (ar_hs || (state_q == S_R));
    assign drop    = discard_q || flush;
    assign lat_inc = (lat_q == LAT_MAX) ? lat_q : (lat_q + LAT_ONE);

    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        inst_addr_d = inst_addr_q;
        inst_data_d = inst_data_q;
        inst_err_d  = inst_err_q;
        lat_d       = lat_q;
        last_lat_d  = last_lat_q;
        discard_d   = discard_q;

        case (state_q)
            S_AR, S_R: begin
                if (r_hs) begin
                    discard_d = 1'b0;
                    if (drop) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_HOLD;
                        inst_data_d = RDATA;
                        inst_err_d  = (RRESP != 2'b00) ? ERR_BUS : ERR_OK;
                        last_lat_d  = lat_q;
                    end
                end else begin
                    lat_d = lat_inc;
                    if (flush) begin
                        discard_d = 1'b1;
                    end
                    if (ar_hs) begin
                        state_d = S_R;
                    end
                end
            end
            S_HOLD: begin
                if (flush || inst_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new request is only possible from IDLE or a consumed HOLD, so it overrides the above.
        if (accept) begin
            inst_addr_d = req_addr;
            if (misaligned) begin
                state_d     = S_HOLD;
                inst_err_d  = ERR_ALIGN;
                inst_data_d = '0;
            end else begin
                state_d   = S_AR;
                araddr_d  = req_addr;
                lat_d     = LAT_ONE;
                discard_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            araddr_q    <= '0;
            inst_addr_q <= '0;
            inst_data_q <= '0;
            inst_err_q  <= ERR_OK;
            lat_q       <= '0;
            last_lat_q  <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            inst_addr_q <= inst_addr_d;
            inst_data_q <= inst_data_d;
            inst_err_q  <= inst_err_d;
            lat_q       <= lat_d;
            last_lat_q  <= last_lat_d;
            discard_q   <= discard_d;
        end
    end

    assign ARVALID    = (state_q == S_AR);
    assign ARADDR     = araddr_q;
    assign RREADY     = (state_q == S_AR) || (state_q == S_R);
    assign inst_valid = (state_q == S_HOLD);
    assign inst_data  = inst_data_q;
    assign inst_addr  = inst_addr_q;
    assign inst_err   = inst_err_q;
    assign last_lat   = last_lat_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24080014_ifu_axi_rd.sv
// Directed bench for ysyx_24080014_ifu_axi_rd: a fetch table driven through a scripted
// AXI responder, followed by hand-written backpressure, flush and reset sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_24080014_ifu_axi_rd;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;   // narrow counter so saturation is reachable quickly

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          flush = 1'b0;
    logic          ARVALID;
    logic          ARREADY = 1'b0;
    logic [AW-1:0] ARADDR;
    logic          RVALID = 1'b0;
    logic          RREADY;
    logic [DW-1:0] RDATA = '0;
    logic [1:0]    RRESP = 2'b00;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_addr;
    logic [1:0]    inst_err;
    logic [LW-1:0] last_lat;

    int total = 0;
    int bad   = 0;

    ysyx_24080014_ifu_axi_rd #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .LAT_W (LW)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data (inst_data),
        .inst_addr (inst_addr),
        .inst_err  (inst_err),
        .last_lat  (last_lat)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] addr;
        bit          mis;
        int          ar_wait;   // ARVALID cycles before ARREADY
        int          r_wait;    // cycles from AR handshake to RVALID (0 = same cycle)
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [1:0]  exp_err;
        logic [31:0] exp_data;
        logic [3:0]  exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge where ARVALID should already be high; returns at the negedge after the R beat.
    task automatic respond(input int ar_wait, input int r_wait, input logic [31:0] rdata,
                           input logic [1:0] rresp, input int flush_at,
                           input logic [31:0] exp_araddr, output int arv_cnt);
        int cyc;
        int ar_cyc;
        bit ar_done;
        bit r_done;
        bit addr_ok;
        bit rr_ok;
        cyc = 0; ar_cyc = -1; ar_done = 0; r_done = 0; addr_ok = 1; rr_ok = 1;
        arv_cnt = 0;
        for (int g = 0; g < 60 && !r_done; g++) begin
            cyc++;
            if (ARVALID) begin
                arv_cnt++;
                if (ARADDR !== exp_araddr) addr_ok = 0;
            end
            ARREADY = !ar_done && (cyc == ar_wait + 1);
            if (ARREADY) ar_cyc = cyc;
            RVALID = (ar_cyc >= 0) && (cyc == ar_cyc + r_wait);
            RDATA  = RVALID ? rdata : 32'h0;
            RRESP  = RVALID ? rresp : 2'b00;
            flush  = (cyc == flush_at);
            if (RVALID && !RREADY) rr_ok = 0;
            @(negedge ACLK);
            if (ARREADY) ar_done = 1;
            if (RVALID) r_done = 1;
            ARREADY = 0; RVALID = 0; flush = 0; RDATA = 32'h0; RRESP = 2'b00;
        end
        chk("r_handshake_done", 64'(r_done), 64'd1);
        chk("araddr_stable", 64'(addr_ok), 64'd1);
        chk("rready_at_rvalid", 64'(rr_ok), 64'd1);
    endtask

    task automatic do_fetch(input vec_t v);
        int n;
        inst_ready = 0;
        req_valid  = 1;
        req_addr   = v.addr;
        @(negedge ACLK);
        req_valid = 0;
        if (v.mis) begin
            chk("mis_no_arvalid", 64'(ARVALID), 64'd0);
        end else begin
            respond(v.ar_wait, v.r_wait, v.rdata, v.rresp, -1, v.addr, n);
            chk("arvalid_cycles", 64'(n), 64'(v.ar_wait + 1));
        end
        chk("inst_valid", 64'(inst_valid), 64'd1);
        chk("inst_data", 64'(inst_data), 64'(v.exp_data));
        chk("inst_addr", 64'(inst_addr), 64'(v.addr));
        chk("inst_err", 64'(inst_err), 64'(v.exp_err));
        chk("last_lat", 64'(last_lat), 64'(v.exp_lat));
        inst_ready = 1;
        @(negedge ACLK);
        inst_ready = 0;
        chk("inst_valid_drop", 64'(inst_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] held;
        bit ok;

        //          addr          mis ar r  rdata         rresp err    data          lat
        vecs[0] = '{32'h80000000, 0, 1, 2, 32'h00000413, 2'b00, 2'b00, 32'h00000413, 4'd4};
        vecs[1] = '{32'h80000004, 0, 0, 0, 32'h00100093, 2'b00, 2'b00, 32'h00100093, 4'd1};
        vecs[2] = '{32'h80000002, 1, 0, 0, 32'h0,        2'b00, 2'b10, 32'h00000000, 4'd1};
        vecs[3] = '{32'h8000000C, 0, 0, 3, 32'hDEADBEEF, 2'b10, 2'b01, 32'hDEADBEEF, 4'd4};
        vecs[4] = '{32'h80000010, 0, 2, 1, 32'h12345678, 2'b11, 2'b01, 32'h12345678, 4'd4};
        vecs[5] = '{32'h80000014, 0, 5, 0, 32'hCAFEF00D, 2'b00, 2'b00, 32'hCAFEF00D, 4'd6};
        vecs[6] = '{32'h80000018, 0, 0, 20, 32'h0000A5A5, 2'b00, 2'b00, 32'h0000A5A5, 4'd15};

        // Reset held with a pending request
        ARESETn = 0; req_valid = 1; req_addr = 32'h80000000;
        repeat (3) begin
            @(negedge ACLK);
            chk("rst_arvalid", 64'(ARVALID), 64'd0);
            chk("rst_inst_valid", 64'(inst_valid), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
        end
        chk("rst_rready", 64'(RREADY), 64'd0);
        chk("rst_last_lat", 64'(last_lat), 64'd0);
        chk("rst_inst_err", 64'(inst_err), 64'd0);
        chk("rst_inst_data", 64'(inst_data), 64'd0);
        ARESETn = 1;
        #1;
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 7; i++) do_fetch(vecs[i]);

        // Backpressure then back-to-back request in the consuming cycle
        req_valid = 1; req_addr = 32'h80000020;
        @(negedge ACLK);
        req_valid = 0;
        respond(0, 0, 32'h00000413, 2'b00, -1, 32'h80000020, n);
        held = inst_data;
        ok = 1;
        repeat (5) begin
            @(negedge ACLK);
            if (!inst_valid || inst_data !== 32'h00000413 || ARVALID) ok = 0;
        end
        chk("hold_stable", 64'(ok), 64'd1);
        chk("hold_data", 64'(held), 64'h00000413);
        inst_ready = 1; req_valid = 1; req_addr = 32'h80000004;
        @(negedge ACLK);
        inst_ready = 0; req_valid = 0;
        chk("b2b_arvalid", 64'(ARVALID), 64'd1);
        chk("b2b_araddr", 64'(ARADDR), 64'h80000004);
        chk("b2b_inst_valid", 64'(inst_valid), 64'd0);
        respond(1, 1, 32'h00200113, 2'b00, -1, 32'h80000004, n);
        chk("b2b_data", 64'(inst_data), 64'h00200113);
        chk("b2b_lat", 64'(last_lat), 64'd3);
        inst_ready = 1;
        @(negedge ACLK);
        inst_ready = 0;

        // Flush while waiting in R: beat consumed, nothing delivered
        req_valid = 1; req_addr = 32'h80000028;
        @(negedge ACLK);
        req_valid = 0;
        respond(0, 3, 32'hBADBAD00, 2'b00, 2, 32'h80000028, n);
        chk("flush_r_inst_valid", 64'(inst_valid), 64'd0);
        chk("flush_r_idle", 64'(req_ready), 64'd1);
        chk("flush_r_lat_kept", 64'(last_lat), 64'd3);
        do_fetch('{32'h80000008, 0, 0, 2, 32'h00000513, 2'b00, 2'b00, 32'h00000513, 4'd3});

        // Flush coincident with the R handshake
        req_valid = 1; req_addr = 32'h80000030;
        @(negedge ACLK);
        req_valid = 0;
        respond(1, 0, 32'h11112222, 2'b00, 2, 32'h80000030, n);
        chk("flush_hs_inst_valid", 64'(inst_valid), 64'd0);
        chk("flush_hs_lat_kept", 64'(last_lat), 64'd3);

        // Flush in AR: ARVALID must stay up until ARREADY
        req_valid = 1; req_addr = 32'h80000034;
        @(negedge ACLK);
        req_valid = 0;
        respond(2, 1, 32'h33334444, 2'b00, 1, 32'h80000034, n);
        chk("flush_ar_arvalid_cycles", 64'(n), 64'd3);
        chk("flush_ar_inst_valid", 64'(inst_valid), 64'd0);

        // Flush in HOLD beats inst_ready and blocks the new request
        req_valid = 1; req_addr = 32'h80000040;
        @(negedge ACLK);
        req_valid = 0;
        respond(0, 0, 32'h55556666, 2'b00, -1, 32'h80000040, n);
        chk("pre_hold_flush_valid", 64'(inst_valid), 64'd1);
        flush = 1; inst_ready = 1; req_valid = 1; req_addr = 32'h80000044;
        #1;
        chk("hold_flush_req_ready", 64'(req_ready), 64'd0);
        @(negedge ACLK);
        flush = 0; inst_ready = 0; req_valid = 0;
        chk("hold_flush_inst_valid", 64'(inst_valid), 64'd0);
        chk("hold_flush_no_ar", 64'(ARVALID), 64'd0);

        // Reset in the middle of a transaction
        req_valid = 1; req_addr = 32'h80000050;
        @(negedge ACLK);
        req_valid = 0;
        chk("mid_arvalid", 64'(ARVALID), 64'd1);
        ARESETn = 0;
        #1;
        chk("mid_rst_arvalid", 64'(ARVALID), 64'd0);
        chk("mid_rst_araddr", 64'(ARADDR), 64'd0);
        chk("mid_rst_rready", 64'(RREADY), 64'd0);
        chk("mid_rst_last_lat", 64'(last_lat), 64'd0);
        chk("mid_rst_inst_addr", 64'(inst_addr), 64'd0);
        @(negedge ACLK);
        ARESETn = 1;
        @(negedge ACLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
